// File: rtl/smart_parking_controller.sv
// smart_parking_controller
//   Car-park entry gate controller. Validates keypad passwords with a retry
//   limit and timed lockout. Tracks lot occupancy up to CAPACITY and turns
//   cars away when the lot is full. Closes the gate if a car backs out of
//   RIGHT_PW without passing.
//
// Ports
//   CLOCK      : system clock, rising edge
//   RESET      : asynchronous active-low reset
//   Entrance   : entry-gate front sensor (level)
//   Exit       : entry-gate rear sensor, car has passed the gate (level)
//   DEPART     : exit-lane sensor, one-cycle pulse per departing car
//   PASSWORD   : keypad value, sampled only while PW_VALID=1
//   PW_VALID   : one-cycle strobe marking a submitted password
//   Green/Red  : gate lamps (registered)
//   INDICATOR  : current state code (registered)
//   OCCUPANCY  : cars currently in the lot
//   FULL       : OCCUPANCY == CAPACITY
//   LOCKED     : FSM is in LOCKOUT (registered)
module smart_parking_controller #(
  parameter int                  PW_WIDTH         = 4,
  parameter logic [PW_WIDTH-1:0] PW_VALUE         = 4'b1011,
  parameter int                  CAPACITY         = 8,
  parameter int                  MAX_TRIES        = 3,
  parameter int                  LOCKOUT_CYCLES   = 16,
  parameter int                  GATE_OPEN_CYCLES = 4
) (
  input  logic                          CLOCK,
  input  logic                          RESET,
  input  logic                          Entrance,
  input  logic                          Exit,
  input  logic                          DEPART,
  input  logic [PW_WIDTH-1:0]           PASSWORD,
  input  logic                          PW_VALID,
  output logic                          Green,
  output logic                          Red,
  output logic [2:0]                    INDICATOR,
  output logic [$clog2(CAPACITY+1)-1:0] OCCUPANCY,
  output logic                          FULL,
  output logic                          LOCKED
);

  // Counter widths; a limit of 1 still needs a 1-bit register.
  localparam int OCC_W = $clog2(CAPACITY+1);
  localparam int TRY_W = (MAX_TRIES > 1)        ? $clog2(MAX_TRIES)        : 1;
  localparam int LCK_W = (LOCKOUT_CYCLES > 1)   ? $clog2(LOCKOUT_CYCLES)   : 1;
  localparam int GT_W  = (GATE_OPEN_CYCLES > 1) ? $clog2(GATE_OPEN_CYCLES) : 1;

  localparam logic [OCC_W-1:0] CAP      = OCC_W'(CAPACITY);
  localparam logic [TRY_W-1:0] TRY_LAST = TRY_W'(MAX_TRIES-1);
  localparam logic [LCK_W-1:0] LCK_LAST = LCK_W'(LOCKOUT_CYCLES-1);
  localparam logic [GT_W-1:0]  GT_LAST  = GT_W'(GATE_OPEN_CYCLES-1);

  typedef enum logic [2:0] {
    IDLE        = 3'b000,
    WAIT_PW     = 3'b001,
    WRONG_PW    = 3'b010,
    RIGHT_PW    = 3'b011,
    STOP        = 3'b100,
    LOCKOUT     = 3'b101,
    FULL_REJECT = 3'b110
  } state_t;

  state_t           state, nxt;
  logic [TRY_W-1:0] tries, tries_n;
  logic [LCK_W-1:0] lck_tmr, lck_n;
  logic [GT_W-1:0]  gate_tmr, gt_n;
  logic [OCC_W-1:0] occ_n;
  logic             inc;
  logic             red_n;

  assign FULL = (OCCUPANCY == CAP);

  // Next-state and counter updates.
  always_comb begin
    nxt     = state;
    tries_n = tries;
    lck_n   = lck_tmr;
    gt_n    = gate_tmr;
    inc     = 1'b0;
    unique case (state)
      IDLE: begin
        if (Entrance) nxt = FULL ? FULL_REJECT : WAIT_PW;
      end
      FULL_REJECT: begin
        if (!Entrance || !FULL) nxt = IDLE;
      end
      WAIT_PW, WRONG_PW: begin
        // A submitted password wins over the car backing out in the same cycle.
        if (PW_VALID) begin
          if (PASSWORD == PW_VALUE) begin
            nxt     = RIGHT_PW;
            tries_n = '0;
            gt_n    = '0;
          end else if (tries == TRY_LAST) begin
            nxt   = LOCKOUT;
            lck_n = '0;
          end else begin
            nxt     = WRONG_PW;
            tries_n = tries + 1'b1;
          end
        end else if (!Entrance) begin
          // Backing out keeps the retry count so drivers can't reset it.
          nxt = IDLE;
        end
      end
      RIGHT_PW: begin
        if (Exit) begin
          inc = 1'b1;
          // A car still on the front sensor after passage is a tailgater.
          nxt = Entrance ? STOP : IDLE;
        end else if (gate_tmr == GT_LAST) begin
          nxt = IDLE;
        end else begin
          gt_n = gate_tmr + 1'b1;
        end
      end
      STOP: begin
        if (!Exit) nxt = Entrance ? WAIT_PW : IDLE;
      end
      LOCKOUT: begin
        if (lck_tmr == LCK_LAST) begin
          nxt     = IDLE;
          tries_n = '0;
        end else begin
          lck_n = lck_tmr + 1'b1;
        end
      end
      default: nxt = IDLE;
    endcase
  end

  // Occupancy: a commit and a departure in the same cycle cancel out.
  always_comb begin
    occ_n = OCCUPANCY;
    if (inc && !DEPART) begin
      if (OCCUPANCY != CAP) occ_n = OCCUPANCY + 1'b1;
    end else if (DEPART && !inc) begin
      if (OCCUPANCY != '0) occ_n = OCCUPANCY - 1'b1;
    end
  end

  // Red lamp for the upcoming state; STOP flashes, starting lit on entry.
  always_comb begin
    red_n = 1'b0;
    unique case (nxt)
      WRONG_PW, LOCKOUT, FULL_REJECT: red_n = 1'b1;
      STOP:    red_n = (state == STOP) ? ~Red : 1'b1;
      default: red_n = 1'b0;
    endcase
  end

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      state     <= IDLE;
      tries     <= '0;
      lck_tmr   <= '0;
      gate_tmr  <= '0;
      OCCUPANCY <= '0;
      Green     <= 1'b0;
      Red       <= 1'b0;
      INDICATOR <= 3'b000;
      LOCKED    <= 1'b0;
    end else begin
      state     <= nxt;
      tries     <= tries_n;
      lck_tmr   <= lck_n;
      gate_tmr  <= gt_n;
      OCCUPANCY <= occ_n;
      Green     <= (nxt == RIGHT_PW);
      Red       <= red_n;
      INDICATOR <= nxt;
      LOCKED    <= (nxt == LOCKOUT);
    end
  end

endmodule
